exu_alu_arb: RTL and testbench

EXU_ALU_ARB -- requirements
Module: exu_alu_arb

---
 rtl/exu_alu_arb_if.sv | 64 ++++++
 rtl/exu_alu_arb.sv | 144 ++++++++++++++
 tb/tb_exu_alu_arb.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/exu_alu_arb_if.sv
// Bundle of request, ALU and response signals between two requesters, the arbiter and a shared ALU.
// Latency: none (wires only).
// Backpressure: carried by the req ready and resp ready signals inside the bundle.
// Shared width/function macros: ISA_WIDTH, ALU_FUNC_WIDTH, NO_FUNC, ADD.
`ifndef ISA_WIDTH
`define ISA_WIDTH 32
`endif
`ifndef ALU_FUNC_WIDTH
`define ALU_FUNC_WIDTH 4
`endif
`ifndef NO_FUNC
`define NO_FUNC 4'h0
`endif
`ifndef ADD
`define ADD 4'h1
`endif

interface exu_alu_arb_if;
  // requester 0
  logic                       req0_valid;
  logic                       req0_ready;
  logic [`ISA_WIDTH-1:0]      req0_a;
  logic [`ISA_WIDTH-1:0]      req0_b;
  logic [`ALU_FUNC_WIDTH-1:0] req0_func;
  // requester 1
  logic                       req1_valid;
  logic                       req1_ready;
  logic [`ISA_WIDTH-1:0]      req1_a;
  logic [`ISA_WIDTH-1:0]      req1_b;
  logic [`ALU_FUNC_WIDTH-1:0] req1_func;
  // shared ALU
  logic [`ISA_WIDTH-1:0]      alu_a;
  logic [`ISA_WIDTH-1:0]      alu_b;
  logic [`ALU_FUNC_WIDTH-1:0] alu_func;
  logic [`ISA_WIDTH-1:0]      alu_result;
  // responses
  logic                       resp0_valid;
  logic                       resp0_ready;
  logic                       resp1_valid;
  logic                       resp1_ready;
  logic [`ISA_WIDTH-1:0]      resp_data;
  // status
  logic                       busy;

  // Arbiter side
  modport slave (
    input  req0_valid, req0_a, req0_b, req0_func,
    input  req1_valid, req1_a, req1_b, req1_func,
    input  alu_result, resp0_ready, resp1_ready,
    output req0_ready, req1_ready,
    output alu_a, alu_b, alu_func,
    output resp0_valid, resp1_valid, resp_data, busy
  );

  // Requester / ALU environment side
  modport master (
    output req0_valid, req0_a, req0_b, req0_func,
    output req1_valid, req1_a, req1_b, req1_func,
    output alu_result, resp0_ready, resp1_ready,
    input  req0_ready, req1_ready,
    input  alu_a, alu_b, alu_func,
    input  resp0_valid, resp1_valid, resp_data, busy
  );
endinterface

// File: rtl/exu_alu_arb.sv
// Two-requester arbiter for one shared combinational ALU; one operation in flight at a time.
// Latency: accepted in cycle T (IDLE), result registered in T+1 (ISSUE), response valid from T+2 (RESP).
// Backpressure: owner's resp ready holds RESP with data stable; no new grant until the response is taken.
// Optional feature: define ALU_ARB_RR_EN for round-robin on simultaneous requests (default: requester 0 wins).
`ifndef ISA_WIDTH
`define ISA_WIDTH 32
`endif
`ifndef ALU_FUNC_WIDTH
`define ALU_FUNC_WIDTH 4
`endif
`ifndef NO_FUNC
`define NO_FUNC 4'h0
`endif
`ifndef ADD
`define ADD 4'h1
`endif

module exu_alu_arb (
  input logic          clk,
  input logic          rst,
  exu_alu_arb_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t                     state;
  logic                       owner;        // 0: requester 0 owns the in-flight op, 1: requester 1
  logic [`ISA_WIDTH-1:0]      alu_a_q;
  logic [`ISA_WIDTH-1:0]      alu_b_q;
  logic [`ALU_FUNC_WIDTH-1:0] alu_func_q;
  logic [`ISA_WIDTH-1:0]      resp_data_q;
  logic                       resp0_valid_q;
  logic                       resp1_valid_q;
  logic                       busy_q;

  logic                       grant0;
  logic                       grant1;
  logic                       resp_done;

`ifdef ALU_ARB_RR_EN
  logic                       ptr;          // requester favoured on the next simultaneous request
`endif

  // Winner selection; only meaningful in IDLE and never while reset is asserted.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (rst && (state == IDLE)) begin
`ifdef ALU_ARB_RR_EN
      if (bus.req0_valid && bus.req1_valid) begin
        grant0 = ~ptr;
        grant1 = ptr;
      end else begin
        grant0 = bus.req0_valid;
        grant1 = bus.req1_valid;
      end
`else
      grant0 = bus.req0_valid;
      grant1 = bus.req1_valid & ~bus.req0_valid;
`endif
    end
  end

  // Only the owner's ready completes a response; the other requester's ready is ignored.
  assign resp_done = (resp0_valid_q & bus.resp0_ready) |
                     (resp1_valid_q & bus.resp1_ready);

  // Control FSM with all datapath/status outputs registered alongside the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      owner         <= 1'b0;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_func_q    <= `NO_FUNC;
      resp_data_q   <= '0;
      resp0_valid_q <= 1'b0;
      resp1_valid_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant0 || grant1) begin
            owner      <= grant1;
            alu_a_q    <= grant1 ? bus.req1_a    : bus.req0_a;
            alu_b_q    <= grant1 ? bus.req1_b    : bus.req0_b;
            alu_func_q <= grant1 ? bus.req1_func : bus.req0_func;
            busy_q     <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          // Operands have been stable on the ALU for a full cycle; take the result.
          resp_data_q   <= bus.alu_result;
          resp0_valid_q <= ~owner;
          resp1_valid_q <= owner;
          state         <= RESP;
        end
        RESP: begin
          if (resp_done) begin
            resp0_valid_q <= 1'b0;
            resp1_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            alu_func_q    <= `NO_FUNC;  // park the ALU on a no-op while idle
            state         <= IDLE;
          end
        end
        default: begin
          resp0_valid_q <= 1'b0;
          resp1_valid_q <= 1'b0;
          busy_q        <= 1'b0;
          alu_func_q    <= `NO_FUNC;
          state         <= IDLE;
        end
      endcase
    end
  end

`ifdef ALU_ARB_RR_EN
  // Round-robin pointer flips on every grant so contending requesters alternate.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= 1'b0;
    end else if (grant0 || grant1) begin
      ptr <= ~ptr;
    end
  end
`endif

  assign bus.req0_ready  = grant0;
  assign bus.req1_ready  = grant1;
  assign bus.alu_a       = alu_a_q;
  assign bus.alu_b       = alu_b_q;
  assign bus.alu_func    = alu_func_q;
  assign bus.resp_data   = resp_data_q;
  assign bus.resp0_valid = resp0_valid_q;
  assign bus.resp1_valid = resp1_valid_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_exu_alu_arb.sv
// Testbench for exu_alu_arb: directed scenarios plus randomized traffic against a transaction-level model.
// Latency: model expects response valid two cycles after the accepting cycle.
// Backpressure: randomized resp ready on both requesters, including non-owner readies.
`ifndef ISA_WIDTH
`define ISA_WIDTH 32
`endif
`ifndef ALU_FUNC_WIDTH
`define ALU_FUNC_WIDTH 4
`endif
`ifndef NO_FUNC
`define NO_FUNC 4'h0
`endif
`ifndef ADD
`define ADD 4'h1
`endif

module tb_exu_alu_arb;
  localparam int W = `ISA_WIDTH;
  localparam int F = `ALU_FUNC_WIDTH;
  localparam logic [F-1:0] FN_NONE = `NO_FUNC;
  localparam logic [F-1:0] FN_ADD  = `ADD;
  localparam logic [F-1:0] FN_SUB  = 4'h2;
  localparam logic [F-1:0] FN_AND  = 4'h3;
  localparam logic [F-1:0] FN_OR   = 4'h4;
  localparam logic [F-1:0] FN_XOR  = 4'h5;
`ifdef ALU_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  exu_alu_arb_if bus();

  exu_alu_arb dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [W-1:0] alu_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [F-1:0] f);
    case (f)
      FN_ADD:  return a + b;
      FN_SUB:  return a - b;
      FN_AND:  return a & b;
      FN_OR:   return a | b;
      FN_XOR:  return a ^ b;
      default: return '0;
    endcase
  endfunction

  // Behavioural shared ALU
  assign bus.alu_result = alu_ref(bus.alu_a, bus.alu_b, bus.alu_func);

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  // Transaction-level model: at most one outstanding op, aged in cycles since acceptance.
  bit           m_pend;
  bit           m_owner;
  int           m_age;
  bit           m_ptr;
  logic [W-1:0] m_a, m_b, m_res;
  logic [F-1:0] m_f;
  int           last_grant;

  task automatic model_reset();
    m_pend = 1'b0;
    m_owner = 1'b0;
    m_age = 0;
    m_ptr = 1'b0;
  endtask

  // One cycle: drive inputs at negedge, check against model, advance model for the coming edge.
  task automatic step(input bit v0, input bit v1, input bit r0, input bit r1,
                      input logic [W-1:0] a0, input logic [W-1:0] b0, input logic [F-1:0] f0,
                      input logic [W-1:0] a1, input logic [W-1:0] b1, input logic [F-1:0] f1);
    bit e0, e1, rv;
    @(negedge clk);
    bus.req0_valid = v0; bus.req1_valid = v1;
    bus.resp0_ready = r0; bus.resp1_ready = r1;
    bus.req0_a = a0; bus.req0_b = b0; bus.req0_func = f0;
    bus.req1_a = a1; bus.req1_b = b1; bus.req1_func = f1;
    #1;
    e0 = 1'b0; e1 = 1'b0;
    if (!m_pend) begin
      if (v0 && v1) begin
        if (RR) begin e0 = !m_ptr; e1 = m_ptr; end
        else    begin e0 = 1'b1; end
      end else begin
        e0 = v0; e1 = v1;
      end
    end
    rv = m_pend && (m_age >= 1);
    check("req0_ready", bus.req0_ready, e0);
    check("req1_ready", bus.req1_ready, e1);
    check("resp0_valid", bus.resp0_valid, rv && !m_owner);
    check("resp1_valid", bus.resp1_valid, rv && m_owner);
    check("busy", bus.busy, m_pend);
    if (m_pend) begin
      check("alu_a", bus.alu_a, m_a);
      check("alu_b", bus.alu_b, m_b);
      check("alu_func", bus.alu_func, m_f);
    end else begin
      check("idle_alu_func", bus.alu_func, FN_NONE);
    end
    if (rv) check("resp_data", bus.resp_data, m_res);
    last_grant = e0 ? 0 : (e1 ? 1 : -1);
    // advance model
    if (m_pend) begin
      if (rv && (m_owner ? r1 : r0)) m_pend = 1'b0;
      else m_age++;
    end else if (e0 || e1) begin
      m_pend = 1'b1;
      m_owner = e1;
      m_age = 0;
      m_a = e1 ? a1 : a0;
      m_b = e1 ? b1 : b0;
      m_f = e1 ? f1 : f0;
      m_res = alu_ref(m_a, m_b, m_f);
      if (RR) m_ptr = !m_ptr;
    end
  endtask

  task automatic idle_step(input bit r0, input bit r1);
    step(1'b0, 1'b0, r0, r1, '0, '0, FN_NONE, '0, '0, FN_NONE);
  endtask

  task automatic do_reset(input bit check_clear);
    @(negedge clk);
    rst = 1'b0;
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    bus.resp0_ready = 1'b1; bus.resp1_ready = 1'b1;
    #1;
    if (check_clear) begin
      check("rst_busy", bus.busy, 1'b0);
      check("rst_req0_ready", bus.req0_ready, 1'b0);
      check("rst_req1_ready", bus.req1_ready, 1'b0);
      check("rst_resp0_valid", bus.resp0_valid, 1'b0);
      check("rst_resp1_valid", bus.resp1_valid, 1'b0);
      check("rst_alu_func", bus.alu_func, FN_NONE);
      check("rst_alu_a", bus.alu_a, '0);
      check("rst_resp_data", bus.resp_data, '0);
    end
    model_reset();
    repeat (2) @(negedge clk);
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    rst = 1'b1;
  endtask

  initial begin
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    bus.resp0_ready = 1'b0; bus.resp1_ready = 1'b0;
    bus.req0_a = '0; bus.req0_b = '0; bus.req0_func = FN_NONE;
    bus.req1_a = '0; bus.req1_b = '0; bus.req1_func = FN_NONE;
    model_reset();
    last_grant = -1;

    do_reset(1'b1);

    // Single op: 5 + 7 from requester 0, response two cycles after acceptance
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'd5, 32'd7, FN_ADD, '0, '0, FN_NONE);
    check("single_grant", bus.req0_ready, 1'b1);
    idle_step(1'b0, 1'b0);
    check("single_not_yet", bus.resp0_valid, 1'b0);
    idle_step(1'b1, 1'b0);
    check("single_valid", bus.resp0_valid, 1'b1);
    check("single_data", bus.resp_data, 32'd12);
    idle_step(1'b0, 1'b0);
    check("single_back_idle", bus.busy, 1'b0);

    // Backpressure on requester 1 for four cycles while both keep requesting
    step(1'b0, 1'b1, 1'b0, 1'b0, '0, '0, FN_NONE, 32'd3, 32'd4, FN_SUB);
    idle_step(1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b1, 1'b1, 1'b0, 32'd1, 32'd1, FN_ADD, 32'd2, 32'd2, FN_ADD);
      check("bp_resp1_valid", bus.resp1_valid, 1'b1);
      check("bp_resp_data", bus.resp_data, 32'hFFFF_FFFF);
      check("bp_req0_ready", bus.req0_ready, 1'b0);
      check("bp_req1_ready", bus.req1_ready, 1'b0);
      check("bp_busy", bus.busy, 1'b1);
    end
    idle_step(1'b0, 1'b1);
    idle_step(1'b0, 1'b0);

    // Non-owner handshake must not complete requester 0's response
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h9, 32'h1, FN_XOR, '0, '0, FN_NONE);
    idle_step(1'b0, 1'b1);
    idle_step(1'b0, 1'b1);
    idle_step(1'b0, 1'b1);
    check("nonowner_hold", bus.resp0_valid, 1'b1);
    check("nonowner_data", bus.resp_data, 32'h8);
    idle_step(1'b1, 1'b0);

    // Reset in the middle of ISSUE discards the op
    step(1'b1, 1'b0, 1'b1, 1'b1, 32'd100, 32'd1, FN_ADD, '0, '0, FN_NONE);
    do_reset(1'b1);
    idle_step(1'b1, 1'b1);
    check("post_rst_no_resp", bus.resp0_valid, 1'b0);

    // Contention from reset: both valid, readies always high
    for (int k = 0; k < 12; k++) begin
      int g;
      bit w1;
      step(1'b1, 1'b1, 1'b1, 1'b1, $urandom, $urandom, F'($urandom_range(0, 5)),
           $urandom, $urandom, F'($urandom_range(0, 5)));
      g = k / 3;
      w1 = RR ? g[0] : 1'b0;
      check("cont_req0_ready", bus.req0_ready, (k % 3 == 0) && !w1);
      check("cont_req1_ready", bus.req1_ready, (k % 3 == 0) && w1);
    end

    // Randomized traffic
    for (int k = 0; k < 600; k++) begin
      step($urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0,
           $urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0,
           $urandom, $urandom, F'($urandom_range(0, 5)),
           $urandom, $urandom, F'($urandom_range(0, 5)));
      if (k == 300) do_reset(1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
